// File: rtl/rv6_pkg.sv
// Shared definitions for the RV64 six-stage pipeline (IF, PD, ID, EX, MEM, WB).
// Holds the major opcodes, the NOP encoding, the ID operand-select encodings
// and the control-action encoding that pipe_ctrl uses to steer the stages.
package rv6_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // ID operand source select
   typedef enum logic [1:0] {
      FWD_RF = 2'd0,   // register file
      FWD_XM = 2'd1,   // EX/MEM alu_out
      FWD_MW = 2'd2,   // MEM/WB data
      FWD_LD = 2'd3    // MEM dmem_out (load data)
   } fwd_sel_e;

   // Pipeline action for the current cycle, highest priority last
   typedef enum logic [2:0] {
      CTL_RUN   = 3'd0,
      CTL_IBUSY = 3'd1,
      CTL_REDIR = 3'd2,
      CTL_LDUSE = 3'd3,
      CTL_DBUSY = 3'd4
   } ctl_e;

endpackage

// File: rtl/pipe_ctrl_hz_match.sv
// hz_match: compares one ID source register against one downstream stage's
// destination register.  A hit needs a valid writing stage, an actually used
// source, equal indices, and a non-x0 source (x0 never carries a dependency).
// Ports: stg_vld/stg_wr/stg_rd describe the producing stage, rs/rs_used the
// consuming operand, hit is the combinational result.
module hz_match
   import rv6_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic          stg_vld,
   input  logic          stg_wr,
   input  logic [RW-1:0] stg_rd,
   input  logic [RW-1:0] rs,
   input  logic          rs_used,
   output logic          hit
);

   assign hit = stg_vld & stg_wr & rs_used & (rs != '0) & (stg_rd == rs);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the six-stage RV64 hart.
// Tracks a valid bit per stage register, detects RAW hazards against EX, MEM
// and WB, produces ID forwarding selects, handles redirect kills and bus-wait
// stalls, runs a bus watchdog and keeps saturating event counters.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   i_busy, d_busy                 fetch / data bus waiting
//   redirect                       ID resolved a jalr or mispredict
//   id_rs*, id_rs*_used, id_is_br  ID operand description
//   ex/mem/wb _rd, _wr, _load      producer description per stage
//   stall_*                        hold the stage register (combinational)
//   v_*                            valid bit of each stage register
//   fwd_a, fwd_b                   ID operand select (rv6_pkg::fwd_sel_e)
//   bus_err                        sticky watchdog flag
//   cnt_stall/flush/retire         saturating event counters
module pipe_ctrl
   import rv6_pkg::*;
#(
   parameter int RW     = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32,
   parameter int WDOG   = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_busy,
   input  logic             d_busy,
   input  logic             redirect,
   input  logic [RW-1:0]    id_rs1,
   input  logic [RW-1:0]    id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_is_br,
   input  logic [RW-1:0]    ex_rd,
   input  logic [RW-1:0]    mem_rd,
   input  logic [RW-1:0]    wb_rd,
   input  logic             ex_wr,
   input  logic             mem_wr,
   input  logic             wb_wr,
   input  logic             ex_load,
   input  logic             mem_load,
   output logic             stall_if,
   output logic             stall_pd,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             v_fp,
   output logic             v_pd,
   output logic             v_dx,
   output logic             v_xm,
   output logic             v_mw,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             bus_err,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush,
   output logic [CNT_W-1:0] cnt_retire
);

   localparam bit FWD_ON = (FWD_EN != 0);
   localparam int WD_W   = $clog2(WDOG + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             en);
      return (en && (c != '1)) ? c + CNT_W'(1) : c;
   endfunction

   // A MEM hit is the younger producer, so it wins over WB.
   function automatic logic [1:0] fwd_pick(input logic hit_mem,
                                           input logic hit_wb,
                                           input logic is_load);
      if (!FWD_ON) return FWD_RF;
      if (hit_mem) return is_load ? FWD_LD : FWD_XM;
      if (hit_wb)  return FWD_MW;
      return FWD_RF;
   endfunction

   logic [2:0]    stg_vld, stg_wr;     // [0]=EX, [1]=MEM, [2]=WB
   logic [RW-1:0] stg_rd [3];
   logic [2:0]    hit_a, hit_b;
   logic          any_ex, any_mem, any_wb;
   logic          load_use, interlock, any_stall;
   ctl_e          ctl;
   logic [WD_W-1:0] wd_cnt;

   assign stg_vld  = {v_mw, v_xm, v_dx};
   assign stg_wr   = {wb_wr, mem_wr, ex_wr};
   assign stg_rd[0] = ex_rd;
   assign stg_rd[1] = mem_rd;
   assign stg_rd[2] = wb_rd;

   for (genvar g = 0; g < 3; g++) begin : g_hz
      hz_match #(.RW(RW)) u_rs1 (
         .stg_vld (stg_vld[g]), .stg_wr (stg_wr[g]), .stg_rd (stg_rd[g]),
         .rs      (id_rs1),     .rs_used(id_rs1_used), .hit  (hit_a[g])
      );
      hz_match #(.RW(RW)) u_rs2 (
         .stg_vld (stg_vld[g]), .stg_wr (stg_wr[g]), .stg_rd (stg_rd[g]),
         .rs      (id_rs2),     .rs_used(id_rs2_used), .hit  (hit_b[g])
      );
   end

   assign any_ex  = hit_a[0] | hit_b[0];
   assign any_mem = hit_a[1] | hit_b[1];
   assign any_wb  = hit_a[2] | hit_b[2];

   // Branches consume operands in ID, so an EX producer of any kind, or a
   // load still in MEM, cannot be forwarded in time.
   assign load_use  = (any_ex & ex_load) | (id_is_br & any_ex) |
                      (id_is_br & any_mem & mem_load);
   assign interlock = !FWD_ON && (any_ex || any_mem || any_wb);

   // Action select: stall/forward outputs are forced quiet while in reset.
   always_comb begin
      ctl = CTL_RUN;
      if (rst_n) begin
         if (d_busy)                     ctl = CTL_DBUSY;
         else if (load_use || interlock) ctl = CTL_LDUSE;
         else if (redirect)              ctl = CTL_REDIR;
         else if (i_busy)                ctl = CTL_IBUSY;
      end
   end

   assign stall_if  = (ctl == CTL_DBUSY) || (ctl == CTL_LDUSE) || (ctl == CTL_IBUSY);
   assign stall_pd  = (ctl == CTL_DBUSY) || (ctl == CTL_LDUSE);
   assign stall_id  = stall_pd;
   assign stall_ex  = (ctl == CTL_DBUSY);
   assign stall_mem = stall_ex;
   assign any_stall = stall_if | stall_pd | stall_id | stall_ex | stall_mem;

   assign fwd_a = rst_n ? fwd_pick(hit_a[1], hit_a[2], mem_load) : FWD_RF;
   assign fwd_b = rst_n ? fwd_pick(hit_b[1], hit_b[2], mem_load) : FWD_RF;

   // Stage-register valids, counters and watchdog
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_fp       <= 1'b0;
         v_pd       <= 1'b0;
         v_dx       <= 1'b0;
         v_xm       <= 1'b0;
         v_mw       <= 1'b0;
         cnt_stall  <= '0;
         cnt_flush  <= '0;
         cnt_retire <= '0;
         wd_cnt     <= '0;
         bus_err    <= 1'b0;
      end else begin
         case (ctl)
            CTL_DBUSY: v_mw <= 1'b0;
            CTL_LDUSE: begin
               v_dx <= 1'b0;
               v_xm <= v_dx;
               v_mw <= v_xm;
            end
            default: begin
               // Only a plain run cycle fetches something new into IF/PD.
               v_fp <= (ctl == CTL_RUN);
               v_pd <= (ctl == CTL_REDIR) ? 1'b0 : v_fp;
               v_dx <= v_pd;
               v_xm <= v_dx;
               v_mw <= v_xm;
            end
         endcase

         cnt_stall  <= sat_inc(cnt_stall, any_stall);
         cnt_flush  <= sat_inc(cnt_flush, ctl == CTL_REDIR);
         cnt_retire <= sat_inc(cnt_retire, v_mw && !d_busy);

         if (i_busy || d_busy) begin
            if (wd_cnt != WD_W'(WDOG)) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt >= WD_W'(WDOG - 1)) bus_err <= 1'b1;
         end else begin
            wd_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl.  Two instances share all inputs: dut_a forwards
// (CNT_W=4, WDOG=4) and dut_b interlocks (FWD_EN=0, CNT_W=16, WDOG=1024).
module tb_pipe_ctrl;

   typedef struct packed {
      logic       i_busy, d_busy, redirect;
      logic [4:0] rs1, rs2;
      logic       u1, u2, is_br;
      logic [4:0] ex_rd, mem_rd, wb_rd;
      logic       ex_wr, mem_wr, wb_wr, ex_load, mem_load;
   } in_t;

   typedef struct {
      in_t        in;
      logic [4:0] a_st;   // {if,pd,id,ex,mem}
      logic [1:0] a_fa, a_fb;
      logic [4:0] b_st;
   } vec_t;

   typedef struct packed {
      logic [4:0] v;      // v[0]=IF/PD .. v[4]=MEM/WB
      int         cs, cf, cr, wd;
      logic       err;
   } ms_t;

   typedef struct packed {
      logic [2:0] mode;
      logic [4:0] st;
      logic [1:0] fa, fb;
   } comb_t;

   localparam logic [2:0] M_RUN = 3'd0, M_RED = 3'd1, M_LU = 3'd2,
                          M_BUS = 3'd3, M_RST = 3'd4;

   logic clk = 1'b0;
   logic rst_n;
   logic i_busy, d_busy, redirect, id_rs1_used, id_rs2_used, id_is_br;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic ex_wr, mem_wr, wb_wr, ex_load, mem_load;

   logic [4:0]  a_st, a_v, b_st, b_v;
   logic [1:0]  a_fa, a_fb, b_fa, b_fb;
   logic        a_err, b_err;
   logic [3:0]  a_cs, a_cf, a_cr;
   logic [15:0] b_cs, b_cf, b_cr;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.RW(5), .FWD_EN(1), .CNT_W(4), .WDOG(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_busy(i_busy), .d_busy(d_busy), .redirect(redirect),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_is_br(id_is_br), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load), .mem_load(mem_load),
      .stall_if(a_st[4]), .stall_pd(a_st[3]), .stall_id(a_st[2]), .stall_ex(a_st[1]),
      .stall_mem(a_st[0]), .v_fp(a_v[0]), .v_pd(a_v[1]), .v_dx(a_v[2]), .v_xm(a_v[3]),
      .v_mw(a_v[4]), .fwd_a(a_fa), .fwd_b(a_fb), .bus_err(a_err),
      .cnt_stall(a_cs), .cnt_flush(a_cf), .cnt_retire(a_cr)
   );

   pipe_ctrl #(.RW(5), .FWD_EN(0), .CNT_W(16), .WDOG(1024)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_busy(i_busy), .d_busy(d_busy), .redirect(redirect),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_is_br(id_is_br), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load), .mem_load(mem_load),
      .stall_if(b_st[4]), .stall_pd(b_st[3]), .stall_id(b_st[2]), .stall_ex(b_st[1]),
      .stall_mem(b_st[0]), .v_fp(b_v[0]), .v_pd(b_v[1]), .v_dx(b_v[2]), .v_xm(b_v[3]),
      .v_mw(b_v[4]), .fwd_a(b_fa), .fwd_b(b_fb), .bus_err(b_err),
      .cnt_stall(b_cs), .cnt_flush(b_cf), .cnt_retire(b_cr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input in_t t);
      i_busy = t.i_busy; d_busy = t.d_busy; redirect = t.redirect;
      id_rs1 = t.rs1; id_rs2 = t.rs2; id_rs1_used = t.u1; id_rs2_used = t.u2;
      id_is_br = t.is_br; ex_rd = t.ex_rd; mem_rd = t.mem_rd; wb_rd = t.wb_rd;
      ex_wr = t.ex_wr; mem_wr = t.mem_wr; wb_wr = t.wb_wr;
      ex_load = t.ex_load; mem_load = t.mem_load;
   endtask

   task automatic step_idle(input int n);
      drive('0);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   function automatic bit hit(logic sv, logic wr, logic [4:0] rd, logic [4:0] rs, logic used);
      return sv && wr && used && (rs != 0) && (rd == rs);
   endfunction

   function automatic comb_t mcomb(in_t t, logic rstn, logic [4:0] v, bit fe);
      comb_t c;
      logic [4:0] rs [2];
      logic u [2];
      bit ex_any, mem_any, wb_any;
      c = '0; ex_any = 0; mem_any = 0; wb_any = 0;
      rs[0] = t.rs1; rs[1] = t.rs2; u[0] = t.u1; u[1] = t.u2;
      for (int k = 0; k < 2; k++) begin
         bit he, hm, hw;
         logic [1:0] sel;
         he = hit(v[2], t.ex_wr,  t.ex_rd,  rs[k], u[k]);
         hm = hit(v[3], t.mem_wr, t.mem_rd, rs[k], u[k]);
         hw = hit(v[4], t.wb_wr,  t.wb_rd,  rs[k], u[k]);
         ex_any |= he; mem_any |= hm; wb_any |= hw;
         sel = hm ? (t.mem_load ? 2'd3 : 2'd1) : (hw ? 2'd2 : 2'd0);
         if (!fe || !rstn) sel = 2'd0;
         if (k == 0) c.fa = sel; else c.fb = sel;
      end
      if (!rstn) c.mode = M_RST;
      else if (t.d_busy) c.mode = M_BUS;
      else if ((ex_any && t.ex_load) || (t.is_br && ex_any) ||
               (t.is_br && mem_any && t.mem_load) ||
               (!fe && (ex_any || mem_any || wb_any))) c.mode = M_LU;
      else if (t.redirect) c.mode = M_RED;
      else c.mode = M_RUN;
      case (c.mode)
         M_BUS:   c.st = 5'b11111;
         M_LU:    c.st = 5'b11100;
         M_RUN:   c.st = t.i_busy ? 5'b10000 : 5'b00000;
         default: c.st = 5'b00000;
      endcase
      return c;
   endfunction

   // The pipe is a shift register; a stall freezes everything above
   // position h and drops a bubble (or a new fetch) in at position h.
   function automatic ms_t mstep(ms_t s, in_t t, logic rstn, bit fe, int cmax, int wdog);
      ms_t n;
      comb_t c;
      int h;
      logic ins;
      if (!rstn) return '0;
      n = s;
      c = mcomb(t, rstn, s.v, fe);
      h = (c.mode == M_BUS) ? 4 : (c.mode == M_LU) ? 2 : 0;
      ins = (c.mode == M_RUN) && !t.i_busy;
      for (int k = 0; k < 5; k++) begin
         if (k < h) n.v[k] = s.v[k];
         else if (k == h) n.v[k] = ins;
         else n.v[k] = s.v[k-1];
      end
      if (c.mode == M_RED) n.v[1] = 1'b0;
      if (c.st != 0 && s.cs < cmax) n.cs = s.cs + 1;
      if (c.mode == M_RED && s.cf < cmax) n.cf = s.cf + 1;
      if (s.v[4] && !t.d_busy && s.cr < cmax) n.cr = s.cr + 1;
      n.wd = (t.i_busy || t.d_busy) ? s.wd + 1 : 0;
      n.err = s.err || (n.wd >= wdog);
      return n;
   endfunction

   // ---------------- test ----------------
   vec_t tab[$];
   in_t  t, t_lu;
   ms_t  ma, mb;
   comb_t ca, cb;
   logic [31:0] prev;
   logic rr;

   initial begin
      // table: all valids are full when each vector is applied
      t_lu = '0; t_lu.rs1 = 5; t_lu.u1 = 1; t_lu.ex_rd = 5; t_lu.ex_wr = 1; t_lu.ex_load = 1;
      tab.push_back('{'0, 5'b00000, 2'd0, 2'd0, 5'b00000});
      tab.push_back('{t_lu, 5'b11100, 2'd0, 2'd0, 5'b11100});
      t = '0; t.rs1 = 3; t.u1 = 1; t.mem_rd = 3; t.mem_wr = 1; t.wb_rd = 3; t.wb_wr = 1;
      tab.push_back('{t, 5'b00000, 2'd1, 2'd0, 5'b11100});
      t.rs1 = 0;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd0, 5'b00000});
      t = '0; t.rs2 = 7; t.u2 = 1; t.mem_rd = 7; t.mem_wr = 1; t.mem_load = 1;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd3, 5'b11100});
      t.is_br = 1;
      tab.push_back('{t, 5'b11100, 2'd0, 2'd3, 5'b11100});
      t = '0; t.is_br = 1; t.rs1 = 4; t.u1 = 1; t.ex_rd = 4; t.ex_wr = 1;
      tab.push_back('{t, 5'b11100, 2'd0, 2'd0, 5'b11100});
      t = '0; t.rs2 = 9; t.u2 = 1; t.wb_rd = 9; t.wb_wr = 1;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd2, 5'b11100});
      t = t_lu; t.u1 = 0;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd0, 5'b00000});
      t = t_lu; t.d_busy = 1; t.redirect = 1;
      tab.push_back('{t, 5'b11111, 2'd0, 2'd0, 5'b11111});
      t = '0; t.i_busy = 1;
      tab.push_back('{t, 5'b10000, 2'd0, 2'd0, 5'b10000});
      t = t_lu; t.i_busy = 1;
      tab.push_back('{t, 5'b11100, 2'd0, 2'd0, 5'b11100});
      t = t_lu; t.ex_wr = 0;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd0, 5'b00000});
      t = '0; t.redirect = 1;
      tab.push_back('{t, 5'b00000, 2'd0, 2'd0, 5'b00000});

      // reset state, reset during a bus stall, refill after release
      rst_n = 0; drive('0);
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(a_v), 0);
      chk("rst_stall", 32'(a_st), 0);
      chk("rst_fwd", 32'({a_fa, a_fb}), 0);
      chk("rst_err", 32'(a_err), 0);
      chk("rst_cnt", 32'({a_cs, a_cf, a_cr}), 0);
      rst_n = 1; t = '0; t.d_busy = 1; drive(t);
      repeat (2) @(negedge clk);
      chk("dbusy_cnt", 32'(a_cs), 2);
      rst_n = 0; #1;
      chk("rst_mid_stall", 32'(a_st), 0);
      @(negedge clk);
      chk("rst_mid_cnt", 32'(a_cs), 0);
      chk("rst_mid_valid", 32'(a_v), 0);
      rst_n = 1; drive('0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("refill_valid", 32'(a_v), 32'((1 << k) - 1));
      end
      chk("refill_cnt", 32'({a_cs, a_cf, a_cr}), 0);

      // load-use: one stall, EX bubble, then load data forwarded from MEM
      drive(t_lu); #1;
      chk("lu_stall", 32'(a_st), 32'(5'b11100));
      @(negedge clk);
      chk("lu_valid", 32'(a_v), 32'(5'b11011));
      chk("lu_cnt", 32'(a_cs), 1);
      t = '0; t.rs1 = 5; t.u1 = 1; t.mem_rd = 5; t.mem_wr = 1; t.mem_load = 1;
      drive(t); #1;
      chk("lu_fwd_ld", 32'(a_fa), 3);
      chk("lu_no_stall", 32'(a_st), 0);
      @(negedge clk);
      step_idle(6);

      // combinational vector table
      foreach (tab[i]) begin
         drive(tab[i].in); #1;
         chk($sformatf("vec%0d_a_stall", i), 32'(a_st), 32'(tab[i].a_st));
         chk($sformatf("vec%0d_a_fwd", i), 32'({a_fa, a_fb}), 32'({tab[i].a_fa, tab[i].a_fb}));
         chk($sformatf("vec%0d_b_stall", i), 32'(b_st), 32'(tab[i].b_st));
         chk($sformatf("vec%0d_b_fwd", i), 32'({b_fa, b_fb}), 0);
         @(negedge clk);
         step_idle(6);
      end

      // redirect accepted, then redirect masked by d_busy
      prev = 32'(a_cf);
      t = '0; t.redirect = 1; drive(t);
      @(negedge clk);
      chk("redir_valid", 32'(a_v), 32'(5'b11100));
      chk("redir_cnt", 32'(a_cf), prev + 1);
      step_idle(6);
      t.d_busy = 1; drive(t); #1;
      chk("redir_dbusy_stall", 32'(a_st), 32'(5'b11111));
      @(negedge clk);
      chk("redir_dbusy_valid", 32'(a_v), 32'(5'b01111));
      chk("redir_dbusy_cnt", 32'(a_cf), prev + 1);
      step_idle(6);

      // d_busy held 3 cycles, then watchdog boundary at 4
      prev = 32'(b_cr);
      t = '0; t.d_busy = 1;
      for (int k = 0; k < 3; k++) begin
         drive(t); #1;
         chk("bus_stall", 32'(b_st), 32'(5'b11111));
         @(negedge clk);
         chk("bus_valid", 32'(b_v), 32'(5'b01111));
         chk("bus_retire_frozen", 32'(b_cr), prev);
      end
      chk("wdog_3", 32'(a_err), 0);
      step_idle(1);
      drive(t);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("wdog_cyc%0d", k), 32'(a_err), 32'(k == 4));
      end
      step_idle(2);
      chk("wdog_sticky", 32'(a_err), 1);
      chk("wdog_b_quiet", 32'(b_err), 0);

      // counter saturation: 20 stall cycles
      rst_n = 0; @(negedge clk); rst_n = 1;
      drive(t);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 10 || k == 15 || k == 20)
            chk($sformatf("sat_a_%0d", k), 32'(a_cs), 32'(k < 15 ? k : 15));
      end
      chk("sat_b_20", 32'(b_cs), 20);

      // randomized run against the model
      rst_n = 0; drive('0);
      @(negedge clk);
      ma = '0; mb = '0;
      for (int i = 0; i < 3000; i++) begin
         chk("rnd_a_valid", 32'(a_v), 32'(ma.v));
         chk("rnd_a_cnt", 32'({a_cs, a_cf, a_cr}), 32'({ma.cs[3:0], ma.cf[3:0], ma.cr[3:0]}));
         chk("rnd_a_err", 32'(a_err), 32'(ma.err));
         chk("rnd_b_valid", 32'(b_v), 32'(mb.v));
         chk("rnd_b_cs", 32'(b_cs), 32'(mb.cs));
         chk("rnd_b_cfcr", 32'({b_cf, b_cr}), {mb.cf[15:0], mb.cr[15:0]});
         chk("rnd_b_err", 32'(b_err), 32'(mb.err));
         t.i_busy   = ($urandom_range(0, 7) == 0);
         t.d_busy   = ($urandom_range(0, 7) == 0);
         t.redirect = ($urandom_range(0, 4) == 0);
         t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
         t.u1 = ($urandom_range(0, 3) != 0); t.u2 = ($urandom_range(0, 3) != 0);
         t.is_br = ($urandom_range(0, 3) == 0);
         t.ex_rd = 5'($urandom_range(0, 3)); t.mem_rd = 5'($urandom_range(0, 3));
         t.wb_rd = 5'($urandom_range(0, 3));
         t.ex_wr = ($urandom_range(0, 3) != 0); t.mem_wr = ($urandom_range(0, 3) != 0);
         t.wb_wr = ($urandom_range(0, 3) != 0);
         t.ex_load = ($urandom_range(0, 2) == 0); t.mem_load = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 199) != 0);
         rst_n = rr; drive(t); #1;
         ca = mcomb(t, rr, ma.v, 1'b1);
         cb = mcomb(t, rr, mb.v, 1'b0);
         chk("rnd_a_stall", 32'(a_st), 32'(ca.st));
         chk("rnd_a_fwd", 32'({a_fa, a_fb}), 32'({ca.fa, ca.fb}));
         chk("rnd_b_stall", 32'(b_st), 32'(cb.st));
         chk("rnd_b_fwd", 32'({b_fa, b_fb}), 32'({cb.fa, cb.fb}));
         ma = mstep(ma, t, rr, 1'b1, 15, 4);
         mb = mstep(mb, t, rr, 1'b0, 65535, 1024);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the RV64 hart. It replaces the fixed stall generator with per-stage valid tracking, RAW hazard detection, operand-forwarding selects, redirect flush, bus-wait stalls, a bus watchdog and saturating performance counters. It sits beside the six-stage pipeline (IF, PD, ID, EX, MEM, WB). It drives the stage-register enables and the bubble/kill controls.

Parameters:
RW, 5, register-index width; index 0 is hardwired zero.
FWD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = full interlock, no forwarding.
CNT_W, 32, performance-counter width.
WDOG, 1024, maximum consecutive bus-busy cycles before bus_err.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
i_busy  in  1  instruction fetch waiting on bus
d_busy  in  1  data memory waiting on bus
redirect  in  1  ID resolved jalr or mispredict this cycle
id_rs1, id_rs2  in  RW  ID source registers
id_rs1_used, id_rs2_used  in  1  ID actually reads rs1 / rs2
id_is_br  in  1  ID instruction is a branch or jalr (consumes operands in ID)
ex_rd, mem_rd, wb_rd  in  RW  destination register per stage
ex_wr, mem_wr, wb_wr  in  1  stage writes rd
ex_load, mem_load  in  1  stage holds a load
stall_if, stall_pd, stall_id, stall_ex, stall_mem  out  1  hold the stage register
v_fp, v_pd, v_dx, v_xm, v_mw  out  1  valid bit of each stage register
fwd_a, fwd_b  out  2  ID operand select: 0 regfile, 1 EX/MEM alu_out, 2 MEM/WB d, 3 MEM dmem_out
bus_err  out  1  sticky watchdog flag
cnt_stall, cnt_flush, cnt_retire  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst_n=0 at posedge): all v_* = 0, all stall_* = 0, fwd_* = 0, bus_err = 0, counters = 0, watchdog count = 0.
- A hazard match for stage S requires all of: S valid, S wr, rd == rs, rs != 0, rs used.
- Stall rules, in priority order:
  1. d_busy: stall IF..MEM; v_mw <= 0 (bubble into WB).
  2. Load-use: stall IF, PD, ID; v_dx <= 0. Triggers on any of:
     - a match against EX with ex_load;
     - id_is_br and any match against EX;
     - id_is_br and a match against MEM with mem_load.
  3. FWD_EN=0 interlock: any match against EX, MEM or WB stalls as in rule 2.
  4. redirect: v_fp <= 0, v_pd <= 0 next cycle. Valid only when rules 1–3 are inactive; otherwise ignored, and the held branch re-evaluates later.
  5. i_busy: stall IF only; v_fp <= 0.
- Valid propagation: when not stalled and not killed, each v_* takes the upstream valid; v_fp takes 1 when IF is not busy.
- Forwarding (combinational, FWD_EN=1): MEM match has priority over WB match.
  - MEM match: 3 if mem_load, else 1.
  - WB match: 2.
  - Otherwise 0.
- FWD_EN=0: fwd_* is constantly 0.
- Watchdog: counts consecutive cycles with (i_busy | d_busy). It resets to 0 on any idle cycle. When count reaches WDOG, bus_err <= 1; bus_err stays set until rst_n.
- Counters (registered, saturate at all-ones, no wrap):
  - cnt_stall: +1 each cycle any stall_* is asserted.
  - cnt_flush: +1 per accepted redirect.
  - cnt_retire: +1 each cycle v_mw=1 and d_busy=0.
- Simultaneous events: d_busy with redirect gives stall only, with no kill and no flush count. Load-use with i_busy gives the load-use response; v_fp is held because IF is stalled.
- Reset mid-stall: the next cycle is the reset state with no residual stall.
- Latency: stalls and fwd selects are combinational from the inputs. Valids, counters and bus_err update at the next posedge.

Decomposition:
- Shared package (rv6_pkg): opcode constants (LOAD 7'b0000011, STORE, BRANCH, JALR, JAL, OP, OP_IMM), fwd-select encodings FWD_RF/FWD_XM/FWD_MW/FWD_LD, NOP 32'h13.
- One natural sub-module, hz_match: a combinational rs-vs-rd comparator with valid/used/x0 gating. It is instantiated six times (2 operands × 3 stages).

Test Plan:
- Reset check: reset, then release with no busy → cycle 1 all v_*=0; v_fp=1 after 1 cycle; all valids 1 after 5 cycles; counters 0.
- Load-use: EX load ld x5 with ID reading x5 → stall_if/pd/id=1 for one cycle, v_dx=0; next cycle fwd_a=3, cnt_stall=1.
- Forwarding: ADD x3 in MEM and x3 in WB, ID reads x3 → fwd_a=1. With rs=x0, same writers → fwd_a=0. With FWD_EN=0, same setup → stall asserted, fwd_a=0.
- Redirect: redirect=1 with no stall → next cycle v_fp=v_pd=0, cnt_flush=1. redirect plus d_busy → no kill, cnt_flush unchanged.
- Bus stall: d_busy held 3 cycles → stall_if..stall_mem=1 for 3 cycles, v_mw=0, cnt_retire frozen. WDOG=4 with busy held 4 cycles → bus_err=1, stays 1 after busy drops.
- Counter saturation: CNT_W=4 with 20 stall cycles → cnt_stall=15, holds.
